csel_limb_accumulator: RTL

Sequential carry-resolution stage that sits directly downstream of the 16-bit conditional-sum adder. Each cycle it consumes one 34-bit carry-select bundle (both candidate sums and both candidate carries for one 16-bit limb) and selects the correct candidate from the running carry. It assembles LIMBS limbs, least-significant first, into one wide sum with its final carry-out. A valid/ready handshake on both sides lets the adder stream limbs back-to-back.

---
 rtl/csel_pkg.sv | 12 +
 rtl/csel_limb_select.sv | 12 +
 rtl/csel_limb_accumulator.sv | 77 +++++++
 3 files changed

// File: rtl/csel_pkg.sv
// csel_pkg: shared limb/bundle field layout and FSM state type for the carry-select stages
package csel_pkg;
  localparam int LIMB_W   = 16;
  localparam int BUNDLE_W = 34;
  localparam int C1_BIT   = 33;
  localparam int C0_BIT   = 32;
  localparam int SUM0_HI  = 31;
  localparam int SUM0_LO  = 16;
  localparam int SUM1_HI  = 15;
  localparam int SUM1_LO  = 0;
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} csel_state_t;
endpackage

// File: rtl/csel_limb_select.sv
// csel_limb_select: picks one limb's sum and carry from a carry-select bundle
module csel_limb_select
  import csel_pkg::*;
(
  input  logic [BUNDLE_W-1:0] bundle,
  input  logic                carry_sel,
  output logic [LIMB_W-1:0]   sum,
  output logic                carry
);
  assign sum   = carry_sel ? bundle[SUM1_HI:SUM1_LO] : bundle[SUM0_HI:SUM0_LO];
  assign carry = carry_sel ? bundle[C1_BIT] : bundle[C0_BIT];
endmodule

// File: rtl/csel_limb_accumulator.sv
// csel_limb_accumulator: resolves carries limb by limb and assembles a wide sum
module csel_limb_accumulator
  import csel_pkg::*;
#(
  parameter int LIMBS = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cin,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [BUNDLE_W-1:0]       in_bundle,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LIMB_W*LIMBS-1:0]   out_sum,
  output logic                      out_carry,
  output logic                      busy
);
  localparam int W  = LIMB_W * LIMBS;
  localparam int IW = $clog2(LIMBS);
  localparam logic [IW-1:0] LAST = IW'(LIMBS - 1);

  csel_state_t     state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d, wr_idx;
  logic            rc_q, rc_d;
  logic [W-1:0]    acc_q, acc_d;
  logic            carry_sel, sel_carry;
  logic [LIMB_W-1:0] sel_sum;

  csel_limb_select u_sel (
    .bundle    (in_bundle),
    .carry_sel (carry_sel),
    .sum       (sel_sum),
    .carry     (sel_carry)
  );

  // handshakes, limb placement and state transitions
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    rc_d      = rc_q;
    acc_d     = acc_q;
    in_ready  = state_q != DONE;
    out_valid = state_q == DONE;
    busy      = state_q != IDLE;
    carry_sel = state_q == IDLE ? cin : rc_q;
    wr_idx    = state_q == IDLE ? '0 : idx_q;
    if (in_valid && in_ready) begin
      acc_d[wr_idx*LIMB_W +: LIMB_W] = sel_sum;
      rc_d    = sel_carry;
      idx_d   = wr_idx + 1'b1;
      state_d = wr_idx == LAST ? DONE : ACCUM;
    end
    if (out_valid && out_ready) begin
      state_d = IDLE;
      idx_d   = '0;
    end
  end

  // state registers; reset discards any partial or pending result at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      rc_q    <= 1'b0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rc_q    <= rc_d;
      acc_q   <= acc_d;
    end
  end

  assign out_sum   = acc_q;
  assign out_carry = rc_q;
endmodule
